// File: rtl/oam_dma_bus_arbiter.sv
// CPU memory bus owner: exec beats fetch in IDLE; a write to DMA_REG hands the
// bus to an OAM DMA sequencer that copies one 256-byte page to OAM_DATA.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | CPU owns the bus, combinational exec/fetch grant
// S_HALT  | first stall cycle after the trigger write
// S_ALIGN | extra stall cycle when HALT fell on an odd parity cycle
// S_READ  | read byte {page,idx} from memory
// S_WRITE | write previous read data to OAM_DATA, advance idx
module oam_dma_bus_arbiter #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG    = 16'h4014,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA   = 16'h2004
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    input  logic                  exec_req,
    input  logic                  exec_we,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [REG_WIDTH-1:0]  exec_wdata,
    output logic                  exec_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic [REG_WIDTH-1:0]  rdata,
    output logic                  rdata_valid,
    output logic                  rdata_owner,
    output logic                  cpu_stall,
    output logic                  dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             page;
    logic [7:0]             idx;
    logic                   parity;
    logic [REG_WIDTH-1:0]   rdata_q;
    logic                   rdata_valid_q;
    logic                   rdata_owner_q;
    logic                   dma_trig;
    logic                   cpu_read;
    logic [ADDR_WIDTH-1:0]  dma_addr;

    assign dma_trig = exec_gnt & exec_we & (exec_addr == DMA_REG);
    assign cpu_read = fetch_gnt | (exec_gnt & ~exec_we);
    // Page and index concatenate directly; page FF never carries past $FFFF.
    assign dma_addr = ADDR_WIDTH'({page, idx});

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dma_trig) state_nxt = S_HALT;
            S_HALT:  state_nxt = parity ? S_ALIGN : S_READ;
            S_ALIGN: state_nxt = S_READ;
            S_READ:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            page          <= '0;
            idx           <= '0;
            parity        <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_owner_q <= 1'b0;
        end else begin
            parity        <= ~parity;
            rdata_valid_q <= cpu_read;
            if (cpu_read) rdata_owner_q <= exec_gnt;
            if (rdata_valid_q) rdata_q <= mem_rdata;
            if (dma_trig) begin
                page <= exec_wdata[7:0];
                idx  <= '0;
            end else if (state == S_WRITE) begin
                idx <= idx + 8'd1;
            end
        end
    end

    // Everything is forced low while reset is held, even with requests active.
    always_comb begin
        fetch_gnt = 1'b0;
        exec_gnt  = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cpu_stall = 1'b0;
        dma_busy  = 1'b0;
        if (reset_n) begin
            case (state)
                S_IDLE: begin
                    if (exec_req) begin
                        exec_gnt  = 1'b1;
                        mem_addr  = exec_addr;
                        mem_we    = exec_we;
                        mem_wdata = exec_wdata;
                    end else begin
                        fetch_gnt = fetch_req;
                        mem_addr  = fetch_addr;
                    end
                end
                S_HALT, S_ALIGN, S_READ: begin
                    mem_addr  = dma_addr;
                    cpu_stall = 1'b1;
                    dma_busy  = 1'b1;
                end
                S_WRITE: begin
                    mem_addr  = OAM_DATA;
                    mem_we    = 1'b1;
                    mem_wdata = mem_rdata;
                    cpu_stall = 1'b1;
                    dma_busy  = 1'b1;
                end
                default: begin
                    cpu_stall = 1'b0;
                end
            endcase
        end
    end

    assign rdata       = rdata_valid_q ? mem_rdata : rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata_owner = rdata_owner_q;

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Bench for oam_dma_bus_arbiter: synchronous memory model, directed stimulus,
// read-data and OAM-write scoreboards popped by an independent monitor.
module tb_oam_dma_bus_arbiter;

    logic        phi1;
    logic        reset_n;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_gnt;
    logic        exec_req;
    logic        exec_we;
    logic [15:0] exec_addr;
    logic [7:0]  exec_wdata;
    logic        exec_gnt;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        rdata_owner;
    logic        cpu_stall;
    logic        dma_busy;

    oam_dma_bus_arbiter dut (
        .phi1        (phi1),
        .reset_n     (reset_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_gnt   (fetch_gnt),
        .exec_req    (exec_req),
        .exec_we     (exec_we),
        .exec_addr   (exec_addr),
        .exec_wdata  (exec_wdata),
        .exec_gnt    (exec_gnt),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_owner (rdata_owner),
        .cpu_stall   (cpu_stall),
        .dma_busy    (dma_busy)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    logic [7:0] mem [0:65535];
    always @(posedge phi1) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Free-running bus-cycle parity as seen by the sequencer.
    logic tb_par;
    always @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) tb_par <= 1'b0;
        else          tb_par <= ~tb_par;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] rdq [$];
    logic [7:0] dq  [$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge phi1) begin
        if (reset_n) begin
            if (rdata_valid) begin
                if (rdq.size() == 0) begin
                    chk("rdata_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    e = rdq.pop_front();
                    chk("rdata_owner", {31'd0, rdata_owner}, {31'd0, e[8]});
                    chk("rdata", {24'd0, rdata}, {24'd0, e[7:0]});
                end
            end
            if (dma_busy && mem_we) begin
                chk("dma_wr_addr", {16'd0, mem_addr}, 32'h2004);
                if (dq.size() == 0) chk("dma_wr_unexpected", 32'd1, 32'd0);
                else                chk("dma_wr_data", {24'd0, mem_wdata}, {24'd0, dq.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge phi1);
        #1;
    endtask

    task automatic dma_run(input logic [7:0] pg, input bit align, input logic [7:0] pat,
                           input bit pend, input int exp_stall);
        int n, nwe, nrd, gbad, tries;
        logic [15:0] last_rd;
        n = 0; nwe = 0; nrd = 0; gbad = 0; last_rd = '0;
        cyc();
        tries = 0;
        while (tb_par != (align ? 1'b0 : 1'b1) && tries < 4) begin
            cyc();
            tries++;
        end
        exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h4014; exec_wdata = pg;
        @(negedge phi1);
        chk("trig_exec_gnt", {31'd0, exec_gnt}, 32'd1);
        chk("trig_mem_we", {31'd0, mem_we}, 32'd1);
        chk("trig_mem_addr", {16'd0, mem_addr}, 32'h4014);
        chk("trig_no_stall_yet", {31'd0, cpu_stall}, 32'd0);
        for (int i = 0; i < 256; i++) dq.push_back(8'(i) ^ pat);
        cyc();
        if (pend) begin
            exec_we = 1'b0; exec_addr = 16'h0010;
        end else begin
            exec_req = 1'b0;
        end
        for (int k = 0; k < 700; k++) begin
            @(negedge phi1);
            if (!cpu_stall) break;
            n++;
            if (fetch_gnt || exec_gnt) gbad++;
            if (mem_we) nwe++;
            else begin
                nrd++;
                last_rd = mem_addr;
            end
        end
        chk("stall_cycles", n, exp_stall);
        chk("grants_during_stall", gbad, 0);
        chk("dma_write_cycles", nwe, 256);
        chk("dma_nonwrite_cycles", nrd, align ? 258 : 257);
        chk("dma_last_read_addr", {16'd0, last_rd}, {16'd0, pg, 8'hFF});
        chk("dma_all_writes_seen", dq.size(), 0);
        chk("dma_busy_after", {31'd0, dma_busy}, 32'd0);
        if (pend) begin
            chk("pend_exec_gnt", {31'd0, exec_gnt}, 32'd1);
            chk("pend_mem_addr", {16'd0, mem_addr}, 32'h0010);
            rdq.push_back({1'b1, 8'h33});
            cyc();
            exec_req = 1'b0;
            @(negedge phi1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bit found;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h8000] = 8'hA9;
        mem[16'h0010] = 8'h33;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            mem[16'hFF00 + i] = 8'(i) ^ 8'hC3;
            mem[16'h0500 + i] = 8'(i) ^ 8'h3C;
        end

        reset_n = 1'b0;
        fetch_req = 1'b1; fetch_addr = 16'h1234;
        exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h5555; exec_wdata = 8'hAA;
        #3;
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_grants", {30'd0, fetch_gnt, exec_gnt}, 32'd0);
        chk("rst_stall_busy", {30'd0, cpu_stall, dma_busy}, 32'd0);
        chk("rst_rdata", {23'd0, rdata_valid, rdata}, 32'd0);
        chk("rst_owner", {31'd0, rdata_owner}, 32'd0);
        fetch_req = 1'b0; exec_req = 1'b0; exec_we = 1'b0;
        exec_addr = '0; exec_wdata = '0; fetch_addr = '0;
        @(posedge phi1);
        @(posedge phi1);
        #1 reset_n = 1'b1;

        // Idle bus follows fetch_addr, no grant
        fetch_addr = 16'h4321;
        @(negedge phi1);
        chk("idle_mem_addr", {16'd0, mem_addr}, 32'h4321);
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        chk("idle_grants", {30'd0, fetch_gnt, exec_gnt}, 32'd0);

        // Simultaneous requests: exec first, then fetch
        cyc();
        fetch_req = 1'b1; fetch_addr = 16'h8000;
        exec_req = 1'b1; exec_we = 1'b0; exec_addr = 16'h0010;
        @(negedge phi1);
        chk("arb_exec_gnt", {31'd0, exec_gnt}, 32'd1);
        chk("arb_fetch_wait", {31'd0, fetch_gnt}, 32'd0);
        chk("arb_mem_addr", {16'd0, mem_addr}, 32'h0010);
        rdq.push_back({1'b1, 8'h33});
        cyc();
        exec_req = 1'b0;
        @(negedge phi1);
        chk("fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
        chk("fetch_mem_addr", {16'd0, mem_addr}, 32'h8000);
        rdq.push_back({1'b0, 8'hA9});
        cyc();
        fetch_req = 1'b0;
        cyc();
        @(negedge phi1);
        chk("rdata_valid_drop", {31'd0, rdata_valid}, 32'd0);
        chk("rdata_held", {24'd0, rdata}, 32'hA9);

        // Plain exec write does not trigger DMA
        cyc();
        exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h0300; exec_wdata = 8'h77;
        @(negedge phi1);
        chk("wr_exec_gnt", {31'd0, exec_gnt}, 32'd1);
        chk("wr_mem", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h0300, 8'h77});
        cyc();
        exec_req = 1'b0;
        @(negedge phi1);
        chk("wr_no_dma", {30'd0, cpu_stall, dma_busy}, 32'd0);

        dma_run(8'h02, 1'b0, 8'h5A, 1'b0, 513);
        dma_run(8'h02, 1'b1, 8'h5A, 1'b0, 514);
        dma_run(8'hFF, 1'b0, 8'hC3, 1'b1, 513);

        // Reset in the middle of a DMA
        cyc();
        exec_req = 1'b1; exec_we = 1'b1; exec_addr = 16'h4014; exec_wdata = 8'h05;
        @(negedge phi1);
        chk("rst_trig_gnt", {31'd0, exec_gnt}, 32'd1);
        for (int i = 0; i < 256; i++) dq.push_back(8'(i) ^ 8'h3C);
        cyc();
        exec_req = 1'b0;
        found = 1'b0;
        for (k = 0; k < 400; k++) begin
            @(posedge phi1);
            if (dq.size() == 192) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_idx_40", {31'd0, found}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("midrst_mem_we_wdata", {23'd0, mem_we, mem_wdata}, 32'd0);
        chk("midrst_stall_busy", {30'd0, cpu_stall, dma_busy}, 32'd0);
        chk("midrst_rdata", {23'd0, rdata_valid, rdata}, 32'd0);
        dq.delete();
        @(posedge phi1);
        @(posedge phi1);
        #1 reset_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 16'h8000;
        @(negedge phi1);
        chk("post_rst_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
        chk("post_rst_stall", {30'd0, cpu_stall, dma_busy}, 32'd0);
        chk("post_rst_mem_addr", {16'd0, mem_addr}, 32'h8000);
        rdq.push_back({1'b0, 8'hA9});
        cyc();
        fetch_req = 1'b0;
        cyc();
        cyc();
        @(negedge phi1);
        chk("rdq_drained", rdq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
